uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter DBIT, default 8, number of data bits per frame.
REQ-002 Parameter SB_TICK, default 16, number of s_tick pulses in the stop bit (16 = 1 stop bit, 24 = 1.5, 32 = 2).
REQ-003 clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 s_tick  input  1  16x-baud oversampling enable; one clk cycle wide per pulse.
REQ-006 rx  input  1  serial line, asynchronous to clk, idle high.
REQ-007 rx_dout  output  DBIT  last correctly received data word.
REQ-008 rx_done_tick  output  1  one-cycle pulse marking a completed frame.
REQ-009 frame_err  output  1  one-cycle pulse on a bad stop bit; port exists only when UART_RX_FRAME_ERR_EN is defined.

Function
REQ-010 rx SHALL pass through a 2-flop synchronizer, reset to 1. Internal sampled line rx_s lags rx by 2 clk.
REQ-011 FSM states SHALL be IDLE, START, DATA and STOP. An s_cnt (4 bit), an n_cnt (log2 DBIT) and a DBIT-bit shift register SHALL be kept.
REQ-012 IDLE: when rx_s==0, go to START with s_cnt=0. This check does not depend on s_tick.
REQ-013 Counters SHALL advance only in cycles where s_tick==1. Cycles without s_tick SHALL hold all state.
REQ-014 START: on the s_tick where s_cnt==7 (mid start bit), the FSM SHALL check rx_s.
  - rx_s==0: go to DATA, s_cnt=0, n_cnt=0.
  - rx_s==1: treat it as a glitch and return to IDLE with no output.
  - Otherwise increment s_cnt.
REQ-015 DATA: on the s_tick where s_cnt==15, shift rx_s into the MSB of the shift register (shift right, LSB first on the line) and reset s_cnt.
  - If n_cnt==DBIT-1, go to STOP.
  - Otherwise increment n_cnt.
REQ-016 STOP: on the s_tick where s_cnt==SB_TICK-1, the FSM SHALL go to IDLE. In that same clk edge:
  - rx_dout SHALL load the shift register.
  - rx_done_tick SHALL be 1 for exactly the following clk cycle.
REQ-017 rx_dout SHALL hold its value between completed frames. Partial or aborted frames SHALL never change rx_dout.
REQ-018 rx_done_tick SHALL never be high in two consecutive cycles.
REQ-019 A line held low after STOP SHALL start a new frame immediately from IDLE; no wait for rx high is required.
REQ-020 Back-to-back frames with zero idle time SHALL be received without loss.
REQ-021 rx transitions between s_ticks SHALL have no effect except through the sample points defined in REQ-012, REQ-014, REQ-015 and REQ-016.

Reset
REQ-022 reset_n low SHALL asynchronously force:
  - state=IDLE;
  - s_cnt=0, n_cnt=0, shift register=0;
  - rx_dout=0, rx_done_tick=0, frame_err=0;
  - both synchronizer flops=1.
REQ-023 Reset asserted mid-frame SHALL abort the frame without any done pulse. After release, reception SHALL resume at the next start bit.

Configuration
REQ-024 The macro UART_RX_FRAME_ERR_EN SHALL control framing-error detection.
REQ-025 With UART_RX_FRAME_ERR_EN defined, the stop bit SHALL be sampled on the STOP s_tick where s_cnt==7.
  - If rx_s==0, the completing edge SHALL leave rx_dout unchanged.
  - rx_done_tick SHALL stay 0 and frame_err SHALL pulse for one clk cycle in the cycle rx_done_tick would have occupied.
  - If rx_s==1, behaviour SHALL match REQ-016.
REQ-026 Without UART_RX_FRAME_ERR_EN, the frame_err port and its logic SHALL be absent, and the stop-bit level SHALL be ignored.

Verification
REQ-027 Reset, then drive frame 0xAA (start 0; bits 0,1,0,1,0,1,0,1; stop 1) at 16 s_ticks per bit. Required: one rx_done_tick pulse and rx_dout=0xAA.
REQ-028 Drive rx low for 4 s_ticks, then high. Required: the FSM returns to IDLE, there is no rx_done_tick and rx_dout is unchanged.
REQ-029 Send 0x55 then 0xC3 with no idle gap. Required: two pulses, rx_dout=0x55 then 0xC3, and the gap between pulses is 160 s_ticks.
REQ-030 Assert reset_n low during data bit 3 of 0xF0, then send 0x3C. Required: rx_dout=0 after reset, only one pulse and rx_dout=0x3C.
REQ-031 With UART_RX_FRAME_ERR_EN defined, send 0x81 with the stop bit 0. Required: frame_err pulses once, there is no rx_done_tick and rx_dout keeps its prior value.
REQ-032 Hold s_tick low for 50 clk in mid DATA. Required: the state and counters are frozen and the frame completes correctly after ticks resume.

Source files
------------

// File: rtl/uart_rx.sv
// uart_rx: 16x-oversampled UART receiver (start/DBIT data/stop), LSB first.
// Define UART_RX_FRAME_ERR_EN to add stop-bit checking and the frame_err pulse.
module uart_rx #(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            s_tick,
    input  logic            rx,
    output logic [DBIT-1:0] rx_dout,
    output logic            rx_done_tick
`ifdef UART_RX_FRAME_ERR_EN
    ,
    output logic            frame_err
`endif
);
    localparam int NW = DBIT > 1 ? $clog2(DBIT) : 1;
    // s_cnt widens beyond 4 bits only when the stop bit is longer than 16 ticks
    localparam int SW = SB_TICK > 16 ? $clog2(SB_TICK) : 4;
    localparam logic [SW-1:0] S_MID  = SW'(7);
    localparam logic [SW-1:0] S_END  = SW'(15);
    localparam logic [SW-1:0] S_STOP = SW'(SB_TICK - 1);
    localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t            state_q, state_d;
    logic [SW-1:0]     s_cnt_q, s_cnt_d;
    logic [NW-1:0]     n_cnt_q, n_cnt_d;
    logic [DBIT-1:0]   b_q, b_d;
    logic [DBIT-1:0]   dout_q, dout_d;
    logic              done_q, done_d;
    logic              rx_meta_q, rx_s_q;
`ifdef UART_RX_FRAME_ERR_EN
    logic              stop_bad_q, stop_bad_d;
    logic              ferr_q, ferr_d;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            s_cnt_q    <= '0;
            n_cnt_q    <= '0;
            b_q        <= '0;
            dout_q     <= '0;
            done_q     <= 1'b0;
            rx_meta_q  <= 1'b1;
            rx_s_q     <= 1'b1;
`ifdef UART_RX_FRAME_ERR_EN
            stop_bad_q <= 1'b0;
            ferr_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            s_cnt_q    <= s_cnt_d;
            n_cnt_q    <= n_cnt_d;
            b_q        <= b_d;
            dout_q     <= dout_d;
            done_q     <= done_d;
            rx_meta_q  <= rx;
            rx_s_q     <= rx_meta_q;
`ifdef UART_RX_FRAME_ERR_EN
            stop_bad_q <= stop_bad_d;
            ferr_q     <= ferr_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        s_cnt_d    = s_cnt_q;
        n_cnt_d    = n_cnt_q;
        b_d        = b_q;
        dout_d     = dout_q;
        done_d     = 1'b0;
`ifdef UART_RX_FRAME_ERR_EN
        stop_bad_d = stop_bad_q;
        ferr_d     = 1'b0;
`endif
        case (state_q)
            IDLE: if (!rx_s_q) begin
                state_d = START;
                s_cnt_d = '0;
            end
            START: if (s_tick) begin
                if (s_cnt_q == S_MID) begin
                    if (!rx_s_q) begin
                        state_d = DATA;
                        s_cnt_d = '0;
                        n_cnt_d = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    s_cnt_d = s_cnt_q + 1'b1;
                end
            end
            DATA: if (s_tick) begin
                if (s_cnt_q == S_END) begin
                    b_d     = {rx_s_q, b_q[DBIT-1:1]};
                    s_cnt_d = '0;
                    if (n_cnt_q == N_LAST) state_d = STOP;
                    else n_cnt_d = n_cnt_q + 1'b1;
                end else begin
                    s_cnt_d = s_cnt_q + 1'b1;
                end
            end
            STOP: if (s_tick) begin
`ifdef UART_RX_FRAME_ERR_EN
                if (s_cnt_q == S_MID) stop_bad_d = !rx_s_q;
`endif
                if (s_cnt_q == S_STOP) begin
                    state_d = IDLE;
`ifdef UART_RX_FRAME_ERR_EN
                    done_d  = !stop_bad_q;
                    ferr_d  = stop_bad_q;
                    dout_d  = stop_bad_q ? dout_q : b_q;
`else
                    done_d  = 1'b1;
                    dout_d  = b_q;
`endif
                end else begin
                    s_cnt_d = s_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign rx_dout      = dout_q;
    assign rx_done_tick = done_q;
`ifdef UART_RX_FRAME_ERR_EN
    assign frame_err    = ferr_q;
`endif
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: scoreboard bench for uart_rx; bench drives s_tick every 4 clk and rx per 16 ticks.
module tb_uart_rx;
    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       s_tick = 1'b0;
    logic       rx = 1'b1;
    logic [7:0] rx_dout;
    logic       rx_done_tick;
`ifdef UART_RX_FRAME_ERR_EN
    logic       frame_err;
`endif

    int n_cmp = 0, n_err = 0, n_done = 0, n_ferr = 0;
    int tick_n = 0, last_done_tick = 0, prev_done_tick = 0;
    bit prev_done = 1'b0;
    logic [7:0] exp_q[$];

    uart_rx #(.DBIT(8), .SB_TICK(16)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .s_tick(s_tick),
        .rx(rx),
        .rx_dout(rx_dout),
        .rx_done_tick(rx_done_tick)
`ifdef UART_RX_FRAME_ERR_EN
        ,
        .frame_err(frame_err)
`endif
    );

    always #5 clk = ~clk;

    // scoreboard: every done pulse pops one expected word
    always @(negedge clk) begin
        logic [7:0] e;
        if (reset_n && rx_done_tick === 1'b1) begin
            n_done++;
            n_cmp++;
            if (prev_done) begin
                n_err++;
                $display("FAIL done_consecutive: rx_done_tick=1 two cycles in a row, required single-cycle pulse");
            end
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_done: rx_dout=%h, required no pulse", rx_dout);
            end else begin
                e = exp_q.pop_front();
                if (rx_dout !== e) begin
                    n_err++;
                    $display("FAIL frame_data: rx_dout=%h, required %h", rx_dout, e);
                end
            end
            prev_done_tick = last_done_tick;
            last_done_tick = tick_n;
        end
        prev_done = (rx_done_tick === 1'b1);
`ifdef UART_RX_FRAME_ERR_EN
        if (reset_n && frame_err === 1'b1) n_ferr++;
`endif
    end

    task automatic tick();
        repeat (2) @(posedge clk);
        #1 s_tick = 1'b1;
        tick_n++;
        @(posedge clk);
        #1 s_tick = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic v, input int pause);
        rx = v;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (pause > 0 && i == 7) begin
                repeat (pause) @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input int pause_bit, input bit expect_ok);
        if (expect_ok) exp_q.push_back(d);
        send_bit(1'b0, 0);
        for (int i = 0; i < 8; i++) send_bit(d[i], i == pause_bit ? 50 : 0);
        send_bit(stop, 0);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        rx = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (rx_dout !== 8'h00) begin
            n_err++;
            $display("FAIL reset_dout: rx_dout=%h, required 00", rx_dout);
        end
        n_cmp++;
        if (rx_done_tick !== 1'b0) begin
            n_err++;
            $display("FAIL reset_done: rx_done_tick=%b, required 0", rx_done_tick);
        end
`ifdef UART_RX_FRAME_ERR_EN
        n_cmp++;
        if (frame_err !== 1'b0) begin
            n_err++;
            $display("FAIL reset_ferr: frame_err=%b, required 0", frame_err);
        end
`endif
        @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (4) tick();
    endtask

    task automatic test_basic();
        int n0 = n_done;
        send_frame(8'hAA, 1'b1, -1, 1'b1);
        repeat (8) tick();
        n_cmp++;
        if (n_done !== n0 + 1) begin
            n_err++;
            $display("FAIL basic_count: pulses=%0d, required %0d", n_done - n0, 1);
        end
        n_cmp++;
        if (rx_dout !== 8'hAA) begin
            n_err++;
            $display("FAIL basic_dout: rx_dout=%h, required aa", rx_dout);
        end
    endtask

    task automatic test_glitch();
        int n0 = n_done;
        rx = 1'b0;
        repeat (4) tick();
        rx = 1'b1;
        repeat (20) tick();
        n_cmp++;
        if (n_done !== n0) begin
            n_err++;
            $display("FAIL glitch_count: pulses=%0d, required 0", n_done - n0);
        end
        n_cmp++;
        if (rx_dout !== 8'hAA) begin
            n_err++;
            $display("FAIL glitch_dout: rx_dout=%h, required aa", rx_dout);
        end
    endtask

    task automatic test_back_to_back();
        int n0 = n_done;
        send_frame(8'h55, 1'b1, -1, 1'b1);
        send_frame(8'hC3, 1'b1, -1, 1'b1);
        repeat (8) tick();
        n_cmp++;
        if (n_done !== n0 + 2) begin
            n_err++;
            $display("FAIL b2b_count: pulses=%0d, required 2", n_done - n0);
        end
        n_cmp++;
        if (last_done_tick - prev_done_tick !== 160) begin
            n_err++;
            $display("FAIL b2b_gap: gap=%0d ticks, required 160", last_done_tick - prev_done_tick);
        end
        n_cmp++;
        if (rx_dout !== 8'hC3) begin
            n_err++;
            $display("FAIL b2b_dout: rx_dout=%h, required c3", rx_dout);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] d = 8'hF0;
        int n0 = n_done;
        send_bit(1'b0, 0);
        for (int i = 0; i < 3; i++) send_bit(d[i], 0);
        rx = d[3];
        repeat (8) tick();
        reset_n = 1'b0;
        #2;
        n_cmp++;
        if (rx_dout !== 8'h00) begin
            n_err++;
            $display("FAIL midreset_dout: rx_dout=%h, required 00", rx_dout);
        end
        @(posedge clk);
        #1 reset_n = 1'b1;
        rx = 1'b1;
        repeat (20) tick();
        send_frame(8'h3C, 1'b1, -1, 1'b1);
        repeat (8) tick();
        n_cmp++;
        if (n_done !== n0 + 1) begin
            n_err++;
            $display("FAIL midreset_count: pulses=%0d, required 1", n_done - n0);
        end
        n_cmp++;
        if (rx_dout !== 8'h3C) begin
            n_err++;
            $display("FAIL midreset_dout2: rx_dout=%h, required 3c", rx_dout);
        end
    endtask

    task automatic test_freeze();
        int n0 = n_done;
        send_frame(8'hA5, 1'b1, 4, 1'b1);
        repeat (8) tick();
        n_cmp++;
        if (n_done !== n0 + 1) begin
            n_err++;
            $display("FAIL freeze_count: pulses=%0d, required 1", n_done - n0);
        end
        n_cmp++;
        if (rx_dout !== 8'hA5) begin
            n_err++;
            $display("FAIL freeze_dout: rx_dout=%h, required a5", rx_dout);
        end
    endtask

    task automatic test_stop_bit();
        int n0 = n_done;
        int f0 = n_ferr;
`ifdef UART_RX_FRAME_ERR_EN
        send_frame(8'h81, 1'b0, -1, 1'b0);
        rx = 1'b1;
        repeat (24) tick();
        n_cmp++;
        if (n_ferr !== f0 + 1) begin
            n_err++;
            $display("FAIL ferr_count: frame_err pulses=%0d, required 1", n_ferr - f0);
        end
        n_cmp++;
        if (n_done !== n0) begin
            n_err++;
            $display("FAIL ferr_done: pulses=%0d, required 0", n_done - n0);
        end
        n_cmp++;
        if (rx_dout !== 8'hA5) begin
            n_err++;
            $display("FAIL ferr_dout: rx_dout=%h, required a5", rx_dout);
        end
`else
        send_frame(8'h81, 1'b0, -1, 1'b1);
        rx = 1'b1;
        repeat (24) tick();
        n_cmp++;
        if (n_done !== n0 + 1 || n_ferr !== f0) begin
            n_err++;
            $display("FAIL badstop_count: pulses=%0d, required 1", n_done - n0);
        end
        n_cmp++;
        if (rx_dout !== 8'h81) begin
            n_err++;
            $display("FAIL badstop_dout: rx_dout=%h, required 81", rx_dout);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_basic();
        test_glitch();
        test_back_to_back();
        test_reset_mid();
        test_freeze();
        test_stop_bit();
        n_cmp++;
        if (exp_q.size() !== 0) begin
            n_err++;
            $display("FAIL leftover: %0d expected frames never received, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
